// File: rtl/counter_pkg.sv
// Shared constants and helpers for the cascaded counter chain.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  localparam int unsigned MAX_STAGE_WIDTH = 64;

  // Terminal value for a stage of the given width: all-ones counting up, zero counting down.
  function automatic logic [MAX_STAGE_WIDTH-1:0] terminal_value(input int unsigned width,
                                                                input logic        dir);
    logic [MAX_STAGE_WIDTH-1:0] ones;
    ones = '1;
    return (dir == DIR_UP) ? (ones >> (MAX_STAGE_WIDTH - width)) : '0;
  endfunction

endpackage

// File: rtl/cascade_counter_stage.sv
// One W-bit up/down stage with load, hold and terminal-value detect.
module cascade_counter_stage
  import counter_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up_down,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Load beats saturate-hold, which beats counting.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (hold) begin
      count_d = count_q;
    end else if (en) begin
      count_d = (up_down == DIR_UP) ? (count_q + W'(1)) : (count_q - W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == W'(terminal_value(W, up_down)));

endmodule

// File: rtl/cascade_counter.sv
// Chain of NUM_STAGES counter stages joined by a single-cycle enable ripple.
module cascade_counter
  import counter_pkg::*;
#(
  parameter int unsigned STAGE_WIDTH = 16,
  parameter int unsigned NUM_STAGES  = 4,
  parameter bit          SATURATE    = MODE_WRAP
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              up_down,
  input  logic                              load,
  input  logic [STAGE_WIDTH*NUM_STAGES-1:0] load_value,
  input  logic                              clear_ovf,
  output logic [STAGE_WIDTH*NUM_STAGES-1:0] count,
  output logic [NUM_STAGES-1:0]             stage_tc,
  output logic                              terminal_count,
  output logic                              overflow
);

  logic [NUM_STAGES-1:0] en;
  logic                  tc_all;
  logic                  hold;
  logic                  ovf_d;
  logic                  ovf_q;

  // Stage i is enabled when the request reaches it through every lower terminal stage.
  always_comb begin
    logic carry;
    en    = '0;
    carry = enable;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      en[i] = carry;
      carry = carry & stage_tc[i];
    end
    tc_all = carry;
  end

  assign terminal_count = tc_all;
  assign hold           = SATURATE & tc_all;

  for (genvar g = 0; g < int'(NUM_STAGES); g++) begin : g_stage
    cascade_counter_stage #(
      .W (STAGE_WIDTH)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .en         (en[g]),
      .up_down    (up_down),
      .load       (load),
      .load_value (load_value[g*STAGE_WIDTH +: STAGE_WIDTH]),
      .hold       (hold),
      .count      (count[g*STAGE_WIDTH +: STAGE_WIDTH]),
      .tc         (stage_tc[g])
    );
  end

  // Sticky overflow: a terminal event wins over a same-cycle clear; load suppresses the event.
  always_comb begin
    ovf_d = ovf_q;
    if (!load && tc_all) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Bench for a 3x4-bit chain in wrap and saturate modes against a whole-number reference model.
module tb_cascade_counter;

  localparam int unsigned SW = 4;
  localparam int unsigned NS = 3;
  localparam int unsigned CW = SW * NS;
  localparam logic [CW-1:0] MAXV = '1;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          up_down;
  logic          load;
  logic [CW-1:0] load_value;
  logic          clear_ovf;

  logic [CW-1:0] cnt_o  [2];
  logic [NS-1:0] stc_o  [2];
  logic          tcnt_o [2];
  logic          ovf_o  [2];

  logic [CW-1:0] m_cnt [2];
  logic          m_ovf [2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cascade_counter #(.STAGE_WIDTH(SW), .NUM_STAGES(NS), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_ovf(clear_ovf), .count(cnt_o[0]),
    .stage_tc(stc_o[0]), .terminal_count(tcnt_o[0]), .overflow(ovf_o[0])
  );

  cascade_counter #(.STAGE_WIDTH(SW), .NUM_STAGES(NS), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear_ovf(clear_ovf), .count(cnt_o[1]),
    .stage_tc(stc_o[1]), .terminal_count(tcnt_o[1]), .overflow(ovf_o[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registers.
  task automatic do_cycle(input logic r, input logic e, input logic ud, input logic ld,
                          input logic [CW-1:0] lv, input logic cl);
    logic [NS-1:0] exp_stc;
    logic          exp_tc;
    logic [CW-1:0] nib;
    @(negedge clk);
    reset = r; enable = e; up_down = ud; load = ld; load_value = lv; clear_ovf = cl;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(NS); i++) begin
        nib = (m_cnt[d] >> (i * int'(SW))) & CW'(15);
        exp_stc[i] = ud ? (nib == CW'(15)) : (nib == CW'(0));
      end
      exp_tc = e && (ud ? (m_cnt[d] == MAXV) : (m_cnt[d] == '0));
      check_val(d == 0 ? "wrap.stage_tc" : "sat.stage_tc", 32'(stc_o[d]), 32'(exp_stc));
      check_val(d == 0 ? "wrap.terminal_count" : "sat.terminal_count", 32'(tcnt_o[d]), 32'(exp_tc));
      if (!r) begin
        m_cnt[d] = '0;
        m_ovf[d] = 1'b0;
      end else if (ld) begin
        m_cnt[d] = lv;
        if (cl) m_ovf[d] = 1'b0;
      end else if (exp_tc) begin
        if (d == 0) m_cnt[d] = ud ? '0 : MAXV;
        m_ovf[d] = 1'b1;
      end else begin
        if (e) m_cnt[d] = ud ? CW'(m_cnt[d] + 1) : CW'(m_cnt[d] - 1);
        if (cl) m_ovf[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val(d == 0 ? "wrap.count" : "sat.count", 32'(cnt_o[d]), 32'(m_cnt[d]));
      check_val(d == 0 ? "wrap.overflow" : "sat.overflow", 32'(ovf_o[d]), 32'(m_ovf[d]));
    end
  endtask

  initial begin
    logic [CW-1:0] rv;
    int            sel;
    reset = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = '0; clear_ovf = 1'b0;
    @(posedge clk);
    #1;
    m_cnt[0] = '0; m_cnt[1] = '0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;

    // Reset dominates load/enable, then count up from zero.
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 12'hABC, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 12'hABC, 1'b0);
    check_val("reset.count", 32'(cnt_o[0]), 32'h000);
    check_val("reset.overflow", 32'(ovf_o[0]), 32'h0);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check_val("release.count1", 32'(cnt_o[0]), 32'h001);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check_val("release.count2", 32'(cnt_o[1]), 32'h002);

    // Carry ripple 0x0FF -> 0x100.
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 12'h0FF, 1'b0);
    #3;
    check_val("ripple.stage_tc", 32'(stc_o[0]), 32'b011);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check_val("ripple.count", 32'(cnt_o[0]), 32'h100);
    check_val("ripple.overflow", 32'(ovf_o[0]), 32'h0);

    // Terminal up: wrap vs saturate, with clear on the wrap cycle.
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    check_val("wrap_up.count", 32'(cnt_o[0]), 32'h000);
    check_val("wrap_up.overflow", 32'(ovf_o[0]), 32'h1);
    check_val("sat_up.count", 32'(cnt_o[1]), 32'hFFF);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check_val("sat_up3.count", 32'(cnt_o[1]), 32'hFFF);
    check_val("sat_up3.overflow", 32'(ovf_o[1]), 32'h1);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    check_val("clear_idle.overflow", 32'(ovf_o[0]), 32'h0);

    // Terminal down.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check_val("sat_down.count", 32'(cnt_o[1]), 32'h000);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check_val("wrap_down.count", 32'(cnt_o[0]), 32'hFFF);

    // Down ripple, then direction flip.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 12'h100, 1'b1);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check_val("down_ripple.count", 32'(cnt_o[0]), 32'h0FF);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check_val("flip_up.count", 32'(cnt_o[0]), 32'h100);

    // Load wins over a terminal enable; reset mid-count.
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'h5A3, 1'b0);
    check_val("load_at_tc.count", 32'(cnt_o[0]), 32'h5A3);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 12'h777, 1'b0);
    check_val("reset_mid.count", 32'(cnt_o[0]), 32'h000);

    // Randomised traffic biased toward the chain and stage terminals.
    for (int n = 0; n < 500; n++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: rv = 12'hFFF;
        1: rv = 12'h000;
        2: rv = 12'h0FF;
        3: rv = 12'hF00;
        4: rv = 12'hFFE;
        default: rv = CW'($urandom);
      endcase
      do_cycle(($urandom % 60) != 0, ($urandom % 4) != 0, 1'($urandom), ($urandom % 6) == 0,
               rv, ($urandom % 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
